// File: rtl/example_instruction_prefetch.sv
// Instruction fetch stage: drives the text bus address, captures returned words one
// cycle later into a small FIFO and hands them to the decoder with valid/ready.
module example_instruction_prefetch #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] TEXT_BEGIN = 32'h0040_0000,
  parameter logic [31:0] TEXT_END   = 32'h0040_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_read_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_reg;
  logic          inflight_reg;
  logic [31:0]   inflight_pc_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;

  logic [31:0] fifo_pc_reg    [DEPTH];
  logic [31:0] fifo_word_reg  [DEPTH];
  logic        fifo_fault_reg [DEPTH];

  logic [CW:0] occupancy;
  logic        issue;
  logic        push;
  logic        pop;
  logic        capture_fault;

  // Occupancy uses this cycle's count, so a slot freed by a same-cycle pop waits a cycle.
  assign occupancy     = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
  assign issue         = !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign push          = !redirect_valid && inflight_reg;
  assign pop           = !redirect_valid && instr_valid && instr_ready;
  assign capture_fault = (inflight_pc_reg < TEXT_BEGIN) || (inflight_pc_reg > TEXT_END) ||
                         (inflight_pc_reg[1:0] != 2'b00);

  assign mem_address = fetch_pc_reg;
  assign instr_valid = (count_reg != '0);
  assign instr       = instr_valid ? fifo_word_reg[rd_ptr_reg] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc_reg[rd_ptr_reg]   : 32'h0;
  assign instr_fault = instr_valid ? fifo_fault_reg[rd_ptr_reg] : 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 32'h0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg <= redirect_pc;
      inflight_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= fetch_pc_reg;
        fetch_pc_reg    <= fetch_pc_reg + 32'd4;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Faulting fetches store a zero word since the bus returns garbage outside text.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock) begin
        if (reset) begin
          fifo_pc_reg[gi]    <= 32'h0;
          fifo_word_reg[gi]  <= 32'h0;
          fifo_fault_reg[gi] <= 1'b0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          fifo_pc_reg[gi]    <= inflight_pc_reg;
          fifo_word_reg[gi]  <= capture_fault ? 32'h0 : mem_read_data;
          fifo_fault_reg[gi] <= capture_fault;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) assert (count_reg <= CW'(DEPTH));
  end

endmodule

// File: tb/tb_example_instruction_prefetch.sv
// Directed bench for the fetch stage: a one-cycle-latency text memory model plus
// hand-computed PC sequences for reset, stall, redirect, fault and wrap cases.
module tb_example_instruction_prefetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_address;
  logic [31:0] mem_read_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;

  int n_checks = 0;
  int n_pass   = 0;

  example_instruction_prefetch dut (
    .clock         (clock),
    .reset         (reset),
    .mem_address   (mem_address),
    .mem_read_data (mem_read_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_fault   (instr_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0010_0093;
  endfunction

  // Text memory: word for the address presented last cycle; junk outside text.
  always @(posedge clock) begin
    if (mem_address >= 32'h0040_0000 && mem_address <= 32'h0040_FFFF)
      mem_read_data <= mem_word(mem_address);
    else
      mem_read_data <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Leaves the bench at the negedge of cycle 0 (first cycle with reset low).
  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // Leaves the bench at the negedge of cycle R+1.
  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    mem_read_data = 32'h0;

    // Reset state
    step(); step();
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc",    instr_pc, 32'h0);
    check("rst_fault", {31'h0, instr_fault}, 32'h0);
    check("rst_addr",  mem_address, 32'h0040_0000);

    // Startup latency and streaming
    reset = 1'b0; instr_ready = 1'b1;
    check("c0_addr", mem_address, 32'h0040_0000);
    step();
    check("c1_valid", {31'h0, instr_valid}, 32'h0);
    step();
    check("c2_valid", {31'h0, instr_valid}, 32'h1);
    check("c2_pc",    instr_pc, 32'h0040_0000);
    check("c2_instr", instr, mem_word(32'h0040_0000));
    step();
    check("c3_pc", instr_pc, 32'h0040_0004);
    step();
    check("c4_pc", instr_pc, 32'h0040_0008);
    check("c4_instr", instr, mem_word(32'h0040_0008));

    // Decoder stall, then drain without loss or gaps
    do_reset();
    for (int i = 0; i < 10; i++) step();
    check("stall_addr",  mem_address, 32'h0040_0010);
    check("stall_valid", {31'h0, instr_valid}, 32'h1);
    check("stall_pc",    instr_pc, 32'h0040_0000);
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("drain_pc%0d", i), instr_pc, 32'h0040_0000 + 32'(4 * i));
      step();
    end

    // Redirect with 3 buffered and one in flight
    do_reset();
    step(); step(); step(); step();
    check("pre_redir_pc", instr_pc, 32'h0040_0000);
    instr_ready = 1'b1;
    do_redirect(32'h0040_0100);
    check("r1_valid", {31'h0, instr_valid}, 32'h0);
    check("r1_addr",  mem_address, 32'h0040_0100);
    step();
    check("r2_valid", {31'h0, instr_valid}, 32'h0);
    step();
    check("r3_valid", {31'h0, instr_valid}, 32'h1);
    check("r3_pc",    instr_pc, 32'h0040_0100);
    step();
    check("r4_pc",    instr_pc, 32'h0040_0104);

    // Out-of-range redirect target, held at head
    instr_ready = 1'b0;
    do_redirect(32'h0050_0000);
    step(); step();
    check("oor_pc",    instr_pc, 32'h0050_0000);
    check("oor_fault", {31'h0, instr_fault}, 32'h1);
    check("oor_instr", instr, 32'h0);

    // Misaligned target inside text
    do_redirect(32'h0040_0102);
    step(); step();
    check("mis_pc",    instr_pc, 32'h0040_0102);
    check("mis_fault", {31'h0, instr_fault}, 32'h1);
    check("mis_instr", instr, 32'h0);

    // Last valid text word then first word past TEXT_END
    instr_ready = 1'b1;
    do_redirect(32'h0040_FFFC);
    step(); step();
    check("end_pc",     instr_pc, 32'h0040_FFFC);
    check("end_fault",  {31'h0, instr_fault}, 32'h0);
    check("end_instr",  instr, mem_word(32'h0040_FFFC));
    step();
    check("past_pc",    instr_pc, 32'h0041_0000);
    check("past_fault", {31'h0, instr_fault}, 32'h1);

    // Reset wins over redirect and handshake mid-stream
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1234_5678; instr_ready = 1'b1;
    step();
    check("mrst_valid", {31'h0, instr_valid}, 32'h0);
    check("mrst_addr",  mem_address, 32'h0040_0000);
    check("mrst_instr", instr, 32'h0);
    reset = 1'b0; redirect_valid = 1'b0;
    step();
    check("mrst_c1_valid", {31'h0, instr_valid}, 32'h0);
    step();
    check("mrst_c2_valid", {31'h0, instr_valid}, 32'h1);
    check("mrst_c2_pc",    instr_pc, 32'h0040_0000);

    // Address wrap at the top of the 32-bit space
    do_redirect(32'hFFFF_FFFC);
    step(); step();
    check("wrap_pc0",    instr_pc, 32'hFFFF_FFFC);
    check("wrap_fault0", {31'h0, instr_fault}, 32'h1);
    check("wrap_instr0", instr, 32'h0);
    step();
    check("wrap_pc1",    instr_pc, 32'h0000_0000);
    check("wrap_fault1", {31'h0, instr_fault}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/example_instruction_prefetch.md
# example_instruction_prefetch

Instruction fetch stage sitting directly upstream of the program text memory bus. Owns the fetch PC, drives the bus address every cycle, captures the returned instruction word one cycle later and buffers it in a small FIFO with a valid/ready handshake toward the decoder. A redirect port (branch, jump, trap) flushes buffered and in-flight words and restarts fetch at a new PC.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- RESET_PC, 32'h0040_0000, first fetch address after reset
- TEXT_BEGIN, 32'h0040_0000, lowest valid text address (inclusive)
- TEXT_END, 32'h0040_FFFF, highest valid text address (inclusive)

- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- mem_address  output  32  address to text memory bus; equals fetch_pc
- mem_read_data  input  32  word from bus, valid one cycle after the address
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  32  new fetch address when redirect_valid
- instr_valid  output  1  FIFO head holds an instruction
- instr_ready  input  1  decoder accepts head this cycle
- instr  output  32  instruction word at FIFO head
- instr_pc  output  32  address of that word
- instr_fault  output  1  head word is out of range or misaligned; instr is 0

## Operation
- State: fetch_pc (32), inflight (1), inflight_pc (32), FIFO of DEPTH × {pc 32, word 32, fault 1}, rd/wr pointers (log2 DEPTH), count (log2 DEPTH + 1).
- Reset: fetch_pc = RESET_PC, inflight = 0, count = 0, pointers = 0. Outputs: instr_valid = 0, instr/instr_pc = 0, instr_fault = 0, mem_address = RESET_PC.
- Issue: in a cycle without redirect, issue when count + inflight < DEPTH, where count is this cycle's occupancy (the slot freed by a same-cycle pop is not reused until next cycle). On issue: inflight ← 1, inflight_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 (mod 2^32, wraps silently). No issue: inflight ← 0, fetch_pc holds.
- Capture: when inflight = 1 and no redirect, push {inflight_pc, word, fault}. fault = inflight_pc < TEXT_BEGIN or > TEXT_END or inflight_pc[1:0] ≠ 0; on fault word stored as 32'h0 (bus returns X out of range).
- Pop: instr_valid && instr_ready advances rd pointer. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority): count ← 0, pointers ← 0, inflight ← 0, fetch_pc ← redirect_pc; no push, pop or issue that cycle. Decoder handshake in a redirect cycle is ignored.
- Overflow cannot occur by construction; an assertion checks that count never exceeds DEPTH.
- Reset overrides redirect and all handshakes.

## Timing
- Bus read latency 1: address in cycle N, mem_read_data sampled in cycle N+1.
- Reset released in cycle 0: RESET_PC issued in cycle 0, pushed at end of cycle 1, instr_valid = 1 in cycle 2.
- Redirect asserted in cycle R: redirect_pc on mem_address in R+1, instr_valid for it in R+3. instr_valid = 0 in R+1 and R+2.
- Steady state with instr_ready held high: one instruction per cycle, consecutive instr_pc differing by 4.
- Decoder stalled: issue stops once count + inflight = DEPTH; exactly DEPTH words buffered, none lost or duplicated. Fetch resumes the cycle after the first pop; head-of-line output stays stable while stalled.
- instr, instr_pc, instr_fault come straight from FIFO registers (no combinational path from mem_read_data or instr_ready).

## Test plan
- Reset then instr_ready = 1 with text words 0x00000013, 0x00100093, ...: instr_valid first high in cycle 2, instr_pc 0x00400000, 0x00400004, 0x00400008 on consecutive cycles.
- instr_ready = 0 for 10 cycles: count saturates at 4, mem_address stops at 0x00400010; on release, PCs 0x00400000–0x0040000C delivered in order, then 0x00400010 with no gap beyond one cycle.
- Redirect to 0x00400100 with 3 entries buffered and one in flight: instr_valid low in R+1, R+2; R+3 shows instr_pc 0x00400100; no stale PC ever appears.
- Redirect to 0x00500000 (out of range) and to 0x00400102 (misaligned): instr_fault = 1, instr = 0, instr_pc = redirect target.
- Redirect and instr_ready asserted together with reset high mid-stream: all state returns to reset values; first delivered PC is 0x00400000 two cycles after reset drops.
- fetch_pc near 0xFFFFFFFC via redirect: next PC wraps to 0x00000000, both words flagged instr_fault = 1.
